breakout_game_sequencer: RTL
============================

// Module: breakout_game_sequencer
// PURPOSE
//  Top-level game-flow controller for the Breakout VGA design. Derives a once-per-frame tick from the
//  scan coordinates and runs the IDLE/SERVE/PLAY/LOST/CLEAR/OVER state machine. Gates paddle and ball
//  motion (move_en), commands ball re-serve, and keeps the lives and level counters for the score/HUD logic.
// PARAMETERS
//  FRAME_Y      481  scan line on which the frame tick fires (pixel_x==0); must be outside visible 0..479
//  LIVES_INIT   3    lives loaded at reset and on new game (1..7)
//  MAX_LEVEL    9    highest level; level saturates here
//  SERVE_FRAMES 60   frames spent in SERVE before PLAY (1..255)
//  LOST_FRAMES  90   frames spent in LOST after a miss (1..255)
//  CLEAR_FRAMES 120  frames spent in CLEAR after a level is cleared (1..255)
// PORTS
//  clock        in   1   system clock
//  reset        in   1   asynchronous, active-high
//  pixel_x      in   10  current scan column from VGA sync
//  pixel_y      in   10  current scan row from VGA sync
//  btn_start    in   1   start button, raw, active-high, asynchronous to clock
//  ball_lost    in   1   1-cycle pulse: ball passed below paddle
//  level_clear  in   1   1-cycle pulse: last brick destroyed
//  frame_tick   out  1   1-cycle pulse per frame
//  move_en      out  1   =frame_tick while state==PLAY; paddle/ball step only when high
//  ball_serve   out  1   level high in SERVE: ball held on paddle centre
//  lives        out  3   remaining lives
//  level        out  4   current level, 1..MAX_LEVEL
//  game_state   out  3   IDLE=0 SERVE=1 PLAY=2 LOST=3 CLEAR=4 OVER=5
// BEHAVIOUR
//  Reset values: game_state=IDLE, lives=LIVES_INIT, level=1, frame_tick=0, move_en=0, ball_serve=0,
//   frame counter=0, button sync flops=0.
//  Frame tick: hit = (pixel_y==FRAME_Y && pixel_x==0). frame_tick is registered: high exactly one cycle,
//   the cycle after hit rises (hit_q==0). Coordinates held for several clocks yield one tick only.
//  Start: btn_start passes through a 2-flop synchronizer; start_edge = sync rising edge (1 cycle).
//  Frame counter (8 bit): cleared on every state entry; +1 per frame_tick; state exits when it reaches
//   the state's *_FRAMES value on a frame_tick.
//  Transitions (registered, all outputs registered, no combinational path input->output):
//   IDLE  -start_edge-> SERVE (lives=LIVES_INIT, level=1 reloaded).
//   SERVE -SERVE_FRAMES ticks-> PLAY.
//   PLAY  -level_clear-> CLEAR; -ball_lost-> LOST. Both in the same cycle: CLEAR wins, no life lost.
//   LOST  entry: lives decremented by 1 (never below 0). After LOST_FRAMES ticks: lives==0 -> OVER,
//    else SERVE.
//   CLEAR entry: level+1, saturating at MAX_LEVEL. After CLEAR_FRAMES ticks -> SERVE.
//   OVER  -start_edge-> SERVE with lives=LIVES_INIT, level=1.
//  ball_lost/level_clear ignored outside PLAY. start_edge ignored outside IDLE/OVER.
//  move_en: high only in PLAY on frame_tick cycles; the tick coincident with PLAY->other exit is suppressed.
//  ball_serve: high for every cycle state==SERVE.
//  Reset asserted mid-game: returns to reset values immediately; no pending event survives.
//  Undefined state encodings (6,7) fall back to IDLE on the next clock.
// TESTING
//  Drive scan 800x525 at 1 pixel/4 clocks; check frame_tick once per frame, 1 cycle wide, at y=481,x=0.
//  Reset, pulse btn_start 10 clocks -> SERVE, lives=3, level=1; PLAY after exactly 60 ticks, ball_serve low.
//  In PLAY, 3x ball_lost, each waited out -> lives 2,1,0; third goes LOST->OVER after 90 ticks; move_en=0.
//  ball_lost and level_clear same cycle in PLAY -> CLEAR, lives unchanged, level 1->2; SERVE after 120 ticks.
//  10 level_clears -> level saturates at 9; btn_start in OVER -> SERVE with lives=3, level=1.
//  Assert reset during LOST mid-count -> IDLE, lives=3, level=1, all pulses low; btn_start in PLAY ignored.

Source files
------------

// File: rtl/breakout_game_sequencer.sv
// Breakout game-flow FSM: frame tick from scan position, IDLE/SERVE/PLAY/LOST/CLEAR/OVER, lives/level.
// All outputs registered (one clock after the causing input); no backpressure, inputs are pulses.
module breakout_game_sequencer #(
    parameter int FRAME_Y      = 481,
    parameter int LIVES_INIT   = 3,
    parameter int MAX_LEVEL    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int LOST_FRAMES  = 90,
    parameter int CLEAR_FRAMES = 120
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       btn_start,
    input  logic       ball_lost,
    input  logic       level_clear,
    output logic       frame_tick,
    output logic       move_en,
    output logic       ball_serve,
    output logic [2:0] lives,
    output logic [3:0] level,
    output logic [2:0] game_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_LOST  = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;

    // Exit fires on the tick that brings the count up to *_FRAMES.
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] LOST_LAST  = 8'(LOST_FRAMES - 1);
    localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_FRAMES - 1);
    localparam logic [2:0] LIVES_RST  = 3'(LIVES_INIT);
    localparam logic [3:0] LEVEL_TOP  = 4'(MAX_LEVEL);

    logic       hit, tick_d, start_edge;
    logic       hit_q, tick_q, move_q, serve_q;
    logic       sync1_q, sync2_q, sync3_q;
    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] lives_q, lives_d;
    logic [3:0] level_q, level_d;

    assign hit        = (pixel_y == 10'(FRAME_Y)) && (pixel_x == 10'd0);
    assign tick_d     = hit && !hit_q;
    assign start_edge = sync2_q && !sync3_q;

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        level_d = level_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_edge) begin
                    state_d = S_SERVE;
                    lives_d = LIVES_RST;
                    level_d = 4'd1;
                end
            end
            S_SERVE: begin
                if (tick_q && cnt_q == SERVE_LAST) state_d = S_PLAY;
            end
            S_PLAY: begin
                // A simultaneous clear takes precedence and costs no life.
                if (level_clear) begin
                    state_d = S_CLEAR;
                    level_d = (level_q >= LEVEL_TOP) ? LEVEL_TOP : level_q + 4'd1;
                end else if (ball_lost) begin
                    state_d = S_LOST;
                    lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                end
            end
            S_LOST: begin
                if (tick_q && cnt_q == LOST_LAST)
                    state_d = (lives_q == 3'd0) ? S_OVER : S_SERVE;
            end
            S_CLEAR: begin
                if (tick_q && cnt_q == CLEAR_LAST) state_d = S_SERVE;
            end
            default: state_d = S_IDLE;
        endcase
        cnt_d = (state_d != state_q) ? 8'd0 : cnt_q + {7'd0, tick_q};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_q   <= 1'b0;
            tick_q  <= 1'b0;
            move_q  <= 1'b0;
            serve_q <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            lives_q <= LIVES_RST;
            level_q <= 4'd1;
        end else begin
            hit_q   <= hit;
            tick_q  <= tick_d;
            // Gating on the next state drops the tick that lands on a PLAY exit.
            move_q  <= tick_d && (state_d == S_PLAY);
            serve_q <= (state_d == S_SERVE);
            sync1_q <= btn_start;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lives_q <= lives_d;
            level_q <= level_d;
        end
    end

    assign frame_tick = tick_q;
    assign move_en    = move_q;
    assign ball_serve = serve_q;
    assign lives      = lives_q;
    assign level      = level_q;
    assign game_state = state_q;

endmodule
